barrel_shifter_pipe: RTL and testbench

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

---
 rtl/barrel_shifter_pkg.sv | 16 +
 rtl/barrel_shifter_pipe_shift_stage.sv | 101 ++++++++++
 rtl/barrel_shifter_pipe.sv | 101 ++++++++++
 tb/tb_barrel_shifter_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shifter_pkg.sv
// Shared op encoding and stage-count helper for the pipelined barrel shifter.
// Rotate support is selected by macro BARREL_SHIFTER_ROTATE_EN in the stage/top files.
package barrel_shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  function automatic int stage_count(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/barrel_shifter_pipe_shift_stage.sv
// One registered right-shift stage of the barrel shifter (distance DIST).
// Macro BARREL_SHIFTER_ROTATE_EN adds the ROR wrap-around path.
module shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 4,
  parameter int SHW     = 5,
  parameter int DIST    = 1,
  parameter int REV_OUT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             advance_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [SHW-1:0]   in_shamt_i,
  input  op_e              in_op_i,
  input  logic             in_fill_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   shamt_o,
  output op_e              op_o,
  output logic             fill_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int BIT = $clog2(DIST);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;
  logic [SHW-1:0]   shamt_r;
  op_e              op_r;
  logic             fill_r;
  logic [TAG_W-1:0] tag_r;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] next_data_s;

  // Shift right by DIST when this stage's shamt bit is set.
  always_comb begin
    shifted_s = in_data_i;
    if (in_shamt_i[BIT]) begin
`ifdef BARREL_SHIFTER_ROTATE_EN
      if (in_op_i == OP_ROR) begin
        shifted_s = {in_data_i[DIST-1:0], in_data_i[WIDTH-1:DIST]};
      end else begin
        shifted_s = {{DIST{in_fill_i}}, in_data_i[WIDTH-1:DIST]};
      end
`else
      shifted_s = {{DIST{in_fill_i}}, in_data_i[WIDTH-1:DIST]};
`endif
    end else begin
      shifted_s = in_data_i;
    end
  end

  // The final stage undoes the entry bit-reversal so SLL leaves the pipe registered.
  always_comb begin
    next_data_s = shifted_s;
    if ((REV_OUT != 0) && (in_op_i == OP_SLL)) begin
      for (int i = 0; i < WIDTH; i++) begin
        next_data_s[i] = shifted_s[WIDTH-1-i];
      end
    end else begin
      next_data_s = shifted_s;
    end
  end

  // Stage registers: flush drops the valid, load wins over a simultaneous advance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
      shamt_r <= {SHW{1'b0}};
      op_r    <= OP_SLL;
      fill_r  <= 1'b0;
      tag_r   <= {TAG_W{1'b0}};
    end else if (flush_i) begin
      valid_r <= 1'b0;
    end else if (load_i) begin
      valid_r <= 1'b1;
      data_r  <= next_data_s;
      shamt_r <= in_shamt_i;
      op_r    <= in_op_i;
      fill_r  <= in_fill_i;
      tag_r   <= in_tag_i;
    end else if (advance_i) begin
      valid_r <= 1'b0;
    end
  end

  assign valid_o = valid_r;
  assign data_o  = data_r;
  assign shamt_o = shamt_r;
  assign op_o    = op_r;
  assign fill_o  = fill_r;
  assign tag_o   = tag_r;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROR) with valid/ready flow control.
// Define BARREL_SHIFTER_ROTATE_EN to make op 11 rotate right; otherwise it acts as SRL.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH-1:0]         in_data_i,
  input  logic [$clog2(WIDTH)-1:0] in_shamt_i,
  input  logic [1:0]               in_op_i,
  input  logic [TAG_W-1:0]         in_tag_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WIDTH-1:0]         out_data_o,
  output logic [TAG_W-1:0]         out_tag_o
);

  localparam int L = stage_count(WIDTH);

  logic             valid_s [L];
  logic [WIDTH-1:0] data_s  [L];
  logic [L-1:0]     shamt_s [L];
  op_e              op_s    [L];
  logic             fill_s  [L];
  logic [TAG_W-1:0] tag_s   [L];
  logic [L-1:0]     adv_s;
  logic             ready_s;
  op_e              entry_op_s;
  logic [WIDTH-1:0] entry_data_s;
  logic             entry_fill_s;

  assign entry_op_s = op_e'(in_op_i);

  // Entry: SLL operands are bit-reversed so every stage only shifts right; SRA sign is captured here.
  always_comb begin
    entry_data_s = in_data_i;
    entry_fill_s = 1'b0;
    if (entry_op_s == OP_SLL) begin
      for (int i = 0; i < WIDTH; i++) begin
        entry_data_s[i] = in_data_i[WIDTH-1-i];
      end
    end else begin
      entry_data_s = in_data_i;
    end
    if (entry_op_s == OP_SRA) begin
      entry_fill_s = in_data_i[WIDTH-1];
    end else begin
      entry_fill_s = 1'b0;
    end
  end

  // Advance chain from the output back to stage 0.
  always_comb begin
    adv_s        = {L{1'b0}};
    adv_s[L-1]   = valid_s[L-1] & out_ready_i;
    for (int k = L - 2; k >= 0; k--) begin
      adv_s[k] = valid_s[k] & (~valid_s[k+1] | adv_s[k+1]);
    end
  end

  assign ready_s    = ~rst_i & ~flush_i & (~valid_s[0] | adv_s[0]);
  assign in_ready_o = ready_s;

  for (genvar k = 0; k < L; k++) begin : g_stage
    if (k == 0) begin : g_first
      shift_stage #(
        .WIDTH(WIDTH), .TAG_W(TAG_W), .SHW(L), .DIST(1), .REV_OUT(0)
      ) u_stage (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .load_i(in_valid_i & ready_s), .advance_i(adv_s[k]),
        .in_data_i(entry_data_s), .in_shamt_i(in_shamt_i), .in_op_i(entry_op_s),
        .in_fill_i(entry_fill_s), .in_tag_i(in_tag_i),
        .valid_o(valid_s[k]), .data_o(data_s[k]), .shamt_o(shamt_s[k]),
        .op_o(op_s[k]), .fill_o(fill_s[k]), .tag_o(tag_s[k])
      );
    end else begin : g_next
      shift_stage #(
        .WIDTH(WIDTH), .TAG_W(TAG_W), .SHW(L), .DIST(1 << k),
        .REV_OUT((k == L - 1) ? 1 : 0)
      ) u_stage (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .load_i(adv_s[k-1]), .advance_i(adv_s[k]),
        .in_data_i(data_s[k-1]), .in_shamt_i(shamt_s[k-1]), .in_op_i(op_s[k-1]),
        .in_fill_i(fill_s[k-1]), .in_tag_i(tag_s[k-1]),
        .valid_o(valid_s[k]), .data_o(data_s[k]), .shamt_o(shamt_s[k]),
        .op_o(op_s[k]), .fill_o(fill_s[k]), .tag_o(tag_s[k])
      );
    end
  end

  assign out_valid_o = valid_s[L-1];
  assign out_data_o  = data_s[L-1];
  assign out_tag_o   = tag_s[L-1];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe (WIDTH=32, five stages).
// Expectations follow BARREL_SHIFTER_ROTATE_EN when it is defined.
module tb_barrel_shifter_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic [4:0]  in_shamt_i;
  logic [1:0]  in_op_i;
  logic [3:0]  in_tag_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [3:0]  out_tag_o;

  barrel_shifter_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_shamt_i(in_shamt_i), .in_op_i(in_op_i), .in_tag_i(in_tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_tag_o(out_tag_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs [14];
  exp_t q [$];
  exp_t head;
  int   idx, acc, popped, lat;
  logic rdy, stall_prev;
  logic [31:0] data_prev;
  logic [3:0]  tag_prev;
  logic [1:0]  rop;
  logic [31:0] rdata;
  logic [4:0]  rsh;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
    case (op)
      2'b00: return d << sh;
      2'b01: return d >> sh;
      2'b10: return $unsigned($signed(d) >>> sh);
      default: begin
`ifdef BARREL_SHIFTER_ROTATE_EN
        if (sh == 5'd0) return d;
        return (d >> sh) | (d << (6'd32 - {1'b0, sh}));
`else
        return d >> sh;
`endif
      end
    endcase
  endfunction

  // Offers one op (caller is just after a rising edge) and checks latency, data and tag.
  task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                        input logic [3:0] tag, input logic [31:0] exp, input string nm);
    int l;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_op_i     = op;
    in_data_i   = d;
    in_shamt_i  = sh;
    in_tag_i    = tag;
    #1;
    check({nm, "_ready"}, {63'd0, in_ready_o}, 64'd1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    l = 0;
    for (int c = 1; c <= 20 && l == 0; c++) begin
      if (c > 1) begin
        @(posedge clk_i); #1;
      end
      if (out_valid_o) l = c;
    end
    check({nm, "_latency"}, 64'(l), 64'd5);
    check({nm, "_data"}, {32'd0, out_data_o}, {32'd0, exp});
    check({nm, "_tag"}, {60'd0, out_tag_o}, {60'd0, tag});
  endtask

  // Launches three back-to-back ops so the pipe holds work in flight.
  task automatic launch3();
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1;
      in_op_i    = 2'b01;
      in_data_i  = 32'hDEAD_0000 + 32'(i);
      in_shamt_i = 5'd1;
      in_tag_i   = 4'(i + 1);
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{2'b10, 32'h8000_0000, 5'd31, 4'h1, 32'hFFFF_FFFF};
    vecs[1]  = '{2'b01, 32'h8000_0000, 5'd31, 4'h2, 32'h0000_0001};
    vecs[2]  = '{2'b00, 32'h0000_0001, 5'd31, 4'h3, 32'h8000_0000};
    vecs[3]  = '{2'b01, 32'h8000_0000, 5'd4,  4'h4, 32'h0800_0000};
    vecs[4]  = '{2'b00, 32'hA5A5_A5A5, 5'd0,  4'h5, 32'hA5A5_A5A5};
    vecs[5]  = '{2'b01, 32'hA5A5_A5A5, 5'd0,  4'h6, 32'hA5A5_A5A5};
    vecs[6]  = '{2'b10, 32'hA5A5_A5A5, 5'd0,  4'h7, 32'hA5A5_A5A5};
    vecs[7]  = '{2'b11, 32'hA5A5_A5A5, 5'd0,  4'h8, 32'hA5A5_A5A5};
    vecs[8]  = '{2'b10, 32'h7FFF_FFFF, 5'd4,  4'h9, 32'h07FF_FFFF};
    vecs[9]  = '{2'b00, 32'hF0F0_F0F0, 5'd4,  4'hA, 32'h0F0F_0F00};
    vecs[10] = '{2'b10, 32'hF000_0000, 5'd5,  4'hB, 32'hFF80_0000};
    vecs[11] = '{2'b00, 32'h1234_5678, 5'd16, 4'hC, 32'h5678_0000};
`ifdef BARREL_SHIFTER_ROTATE_EN
    vecs[12] = '{2'b11, 32'h1234_5678, 5'd8,  4'hD, 32'h7812_3456};
    vecs[13] = '{2'b11, 32'h0000_0001, 5'd1,  4'hE, 32'h8000_0000};
`else
    vecs[12] = '{2'b11, 32'h1234_5678, 5'd8,  4'hD, 32'h0012_3456};
    vecs[13] = '{2'b11, 32'h0000_0001, 5'd1,  4'hE, 32'h0000_0000};
`endif

    // Reset with an offer pending: nothing accepted, outputs cleared.
    rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_op_i = 2'b01; in_data_i = 32'h1; in_shamt_i = 5'd0; in_tag_i = 4'h0;
    @(posedge clk_i); @(posedge clk_i); #1;
    check("rst_in_ready", {63'd0, in_ready_o}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    check("rst_out_data", {32'd0, out_data_o}, 64'd0);
    check("rst_out_tag", {60'd0, out_tag_o}, 64'd0);
    rst_i = 1'b0; in_valid_i = 1'b0;
    #1;
    check("post_rst_ready", {63'd0, in_ready_o}, 64'd1);
    @(posedge clk_i); #1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].tag, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Back-pressure: eight offers against a stalled consumer for ten cycles.
    @(posedge clk_i); #1;
    out_ready_i = 1'b0; idx = 0; acc = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid_i = (idx < 8);
      in_op_i = 2'b01; in_data_i = 32'h8000_0000; in_shamt_i = 5'(idx); in_tag_i = 4'(idx);
      #1;
      rdy = in_ready_o;
      if (acc == 5) check($sformatf("stall_ready_c%0d", c), {63'd0, rdy}, 64'd0);
      if (in_valid_i && rdy) begin
        q.push_back('{model(2'b01, 32'h8000_0000, 5'(idx)), 4'(idx)});
        idx++; acc++;
      end
      @(posedge clk_i); #1;
    end
    check("stall_accepted", 64'(acc), 64'd5);
    out_ready_i = 1'b1; popped = 0;
    for (int c = 0; c < 60 && popped < 8; c++) begin
      in_valid_i = (idx < 8);
      in_op_i = 2'b01; in_data_i = 32'h8000_0000; in_shamt_i = 5'(idx); in_tag_i = 4'(idx);
      #1;
      if (out_valid_o) begin
        if (q.size() == 0) begin
          check("stream_extra", 64'd1, 64'd0);
        end else begin
          head = q.pop_front();
          check($sformatf("stream%0d_tag", popped), {60'd0, out_tag_o}, {60'd0, head.tag});
          check($sformatf("stream%0d_data", popped), {32'd0, out_data_o}, {32'd0, head.data});
        end
        popped++;
      end
      if (in_valid_i && in_ready_o) begin
        q.push_back('{model(2'b01, 32'h8000_0000, 5'(idx)), 4'(idx)});
        idx++;
      end
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
    check("stream_count", 64'(popped), 64'd8);
    q.delete();
    @(posedge clk_i); #1;

    // Flush with work in flight and a simultaneous offer.
    launch3();
    flush_i = 1'b1; in_valid_i = 1'b1; in_tag_i = 4'hF;
    #1;
    check("flush_in_ready", {63'd0, in_ready_o}, 64'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("flush_out_valid", {63'd0, out_valid_o}, 64'd0);
    run_op(2'b01, 32'h0000_00F0, 5'd4, 4'h9, 32'h0000_000F, "post_flush");

    // Reset with work in flight.
    @(posedge clk_i); #1;
    launch3();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("midrst_out_valid", {63'd0, out_valid_o}, 64'd0);
    check("midrst_out_data", {32'd0, out_data_o}, 64'd0);
    run_op(2'b01, 32'h0000_00F0, 5'd4, 4'hA, 32'h0000_000F, "post_rst");
    @(posedge clk_i); #1;

    // Random traffic against the golden model with random back-pressure.
    acc = 0; popped = 0; stall_prev = 1'b0;
    for (int c = 0; c < 12000 && popped < 1000; c++) begin
      if (stall_prev) begin
        check("rand_hold_valid", {63'd0, out_valid_o}, 64'd1);
        check("rand_hold_data", {32'd0, out_data_o}, {32'd0, data_prev});
        check("rand_hold_tag", {60'd0, out_tag_o}, {60'd0, tag_prev});
      end
      out_ready_i = (acc >= 1000) || ($urandom_range(0, 3) != 0);
      in_valid_i  = (acc < 1000) && ($urandom_range(0, 4) != 0);
      rop = 2'($urandom_range(0, 3)); rdata = $urandom(); rsh = 5'($urandom_range(0, 31));
      in_op_i = rop; in_data_i = rdata; in_shamt_i = rsh; in_tag_i = 4'(acc);
      #1;
      if (out_ready_i) check("rand_rate_ready", {63'd0, in_ready_o}, 64'd1);
      if (out_valid_o && out_ready_i) begin
        if (q.size() == 0) begin
          check("rand_spurious", 64'd1, 64'd0);
        end else begin
          head = q.pop_front();
          if (out_data_o !== head.data || out_tag_o !== head.tag)
            check($sformatf("rand%0d_result", popped), {28'd0, out_data_o, out_tag_o}, {28'd0, head.data, head.tag});
          else
            n_tests++;
        end
        popped++;
      end
      if (in_valid_i && in_ready_o) begin
        q.push_back('{model(rop, rdata, rsh), 4'(acc)});
        acc++;
      end
      stall_prev = out_valid_o && !out_ready_i;
      data_prev  = out_data_o;
      tag_prev   = out_tag_o;
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
    check("rand_count", 64'(popped), 64'd1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
